// File: rtl/cart_mem_port.sv
// cart_mem_port: turns each mapped CPU access into a one-shot SDRAM or BRAM request,
// with a one-entry ROM read cache, holding the Z80 via wait_n until data is valid.
module cart_mem_port #(
  parameter int SRAM_AW = 13,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               rd,
  input  logic               wr,
  input  logic [7:0]         d_from_cpu,
  input  logic [24:0]        mem_addr,
  input  logic               sram_oe,
  input  logic               sram_we,
  input  logic [26:0]        rom_base,
  output logic [7:0]         d_to_cpu,
  output logic               wait_n,
  output logic [26:0]        sdram_addr,
  output logic               sdram_req,
  input  logic               sdram_ack,
  input  logic [7:0]         sdram_dout,
  output logic [SRAM_AW-1:0] bram_addr,
  output logic [7:0]         bram_din,
  output logic               bram_wren,
  input  logic [7:0]         bram_dout
);
  localparam logic [1:0] IDLE = 2'd0, SRAM_RD = 2'd1, ROM_REQ = 2'd2, HOLD = 2'd3;
  logic [1:0] state;
  logic act_q, cvalid;
  logic [24:0] ctag;
  logic [7:0] cdata, tcnt;
  logic [26:0] base_q;
  logic [SRAM_AW-1:0] bram_addr_q;
  logic act, start, base_chg, hit, tmo, sram_start;
  assign act = cs & (rd | wr);
  assign start = act & ~act_q;
  assign base_chg = rom_base != base_q;
  assign hit = cvalid & ~base_chg & (ctag == mem_addr);
  assign tmo = (tcnt + 8'd1) == 8'(TIMEOUT);
  assign sram_start = ~reset & (state == IDLE) & start & sram_oe;
  // BRAM read data appears one cycle after the address, so the address bypasses its register on start
  assign bram_addr = sram_start ? mem_addr[SRAM_AW-1:0] : bram_addr_q;
  assign wait_n = ~(start | state == SRAM_RD | state == ROM_REQ);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      act_q <= 1'b0;
      cvalid <= 1'b0;
      ctag <= '0;
      cdata <= '0;
      tcnt <= '0;
      base_q <= '0;
      d_to_cpu <= 8'hFF;
      sdram_req <= 1'b0;
      sdram_addr <= '0;
      bram_wren <= 1'b0;
      bram_addr_q <= '0;
      bram_din <= '0;
    end else begin
      act_q <= act;
      base_q <= rom_base;
      bram_wren <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (sram_oe) begin
            bram_addr_q <= mem_addr[SRAM_AW-1:0];
            if (rd) state <= SRAM_RD;
            else begin
              bram_wren <= sram_we;
              bram_din <= d_from_cpu;
              state <= HOLD;
            end
          end else if (rd & hit) begin
            d_to_cpu <= cdata;
            state <= HOLD;
          end else if (rd) begin
            sdram_addr <= rom_base + {2'b00, mem_addr};
            sdram_req <= 1'b1;
            ctag <= mem_addr;
            cvalid <= 1'b0;
            tcnt <= '0;
            state <= ROM_REQ;
          end else state <= HOLD;
        end
        SRAM_RD: begin
          d_to_cpu <= bram_dout;
          state <= HOLD;
        end
        ROM_REQ: if (sdram_ack) begin
          d_to_cpu <= sdram_dout;
          cdata <= sdram_dout;
          cvalid <= 1'b1;
          sdram_req <= 1'b0;
          tcnt <= '0;
          state <= HOLD;
        end else if (tmo) begin
          d_to_cpu <= 8'hFF;
          cvalid <= 1'b0;
          sdram_req <= 1'b0;
          tcnt <= '0;
          state <= HOLD;
        end else tcnt <= tcnt + 8'd1;
        HOLD: if (!act) state <= IDLE;
      endcase
      if (base_chg) cvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cart_mem_port.sv
// tb_cart_mem_port: directed and random accesses checked against a cache/ROM/SRAM reference model.
module tb_cart_mem_port;
  localparam int TIMEOUT = 255;
  logic clk = 0, reset = 1, cs = 0, rd = 0, wr = 0, sram_oe = 0, sram_we = 0;
  logic [7:0] d_from_cpu = 0, d_to_cpu, bram_din, bram_dout = 0, sdram_dout = 0;
  logic [24:0] mem_addr = 0;
  logic [26:0] rom_base = 0, sdram_addr;
  logic [12:0] bram_addr;
  logic sdram_req, sdram_ack = 0, bram_wren, wait_n;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  cart_mem_port #(.SRAM_AW(13), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .d_from_cpu(d_from_cpu),
    .mem_addr(mem_addr), .sram_oe(sram_oe), .sram_we(sram_we), .rom_base(rom_base),
    .d_to_cpu(d_to_cpu), .wait_n(wait_n), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .sdram_dout(sdram_dout), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_wren(bram_wren), .bram_dout(bram_dout)
  );

  function automatic logic [7:0] rom_byte(input logic [26:0] a);
    return a[7:0] ^ a[15:8] ^ {a[26:24], a[20:16]} ^ 8'hF5;
  endfunction

  logic [7:0] bram [8192];
  always @(posedge clk) begin
    bram_dout <= bram[bram_addr];
    if (bram_wren) bram[bram_addr] <= bram_din;
  end

  // SDRAM responder: ack in the ack_delay-th cycle after the first cycle req is seen; 0 = never
  int ack_delay = 4, rcnt = 0, req_rises = 0, wren_cnt = 0, addr_moves = 0;
  logic req_prev = 0;
  logic [26:0] addr_prev = 0, ack_addr = 0;
  logic [12:0] wren_addr = 0;
  logic [7:0] wren_data = 0;
  always @(posedge clk) begin
    sdram_ack <= 1'b0;
    if (sdram_req && !sdram_ack && ack_delay != 0) begin
      if (rcnt + 1 == ack_delay) begin
        sdram_ack <= 1'b1;
        sdram_dout <= rom_byte(sdram_addr);
        ack_addr <= sdram_addr;
        rcnt <= 0;
      end else rcnt <= rcnt + 1;
    end else if (!sdram_req) rcnt <= 0;
    if (sdram_req && !req_prev) req_rises <= req_rises + 1;
    if (sdram_req && req_prev && sdram_addr !== addr_prev) addr_moves <= addr_moves + 1;
    req_prev <= sdram_req;
    addr_prev <= sdram_addr;
    if (bram_wren) begin
      wren_cnt <= wren_cnt + 1;
      wren_addr <= bram_addr;
      wren_data <= bram_din;
    end
  end

  // reference model: one cached ROM line, SRAM contents, last data shown to the CPU
  bit m_valid = 0;
  logic [24:0] m_tag = 0;
  logic [7:0] m_data = 0, m_d = 8'hFF;
  logic [26:0] cur_base = 0;
  logic [7:0] sram_ref [8192];

  task automatic predict(input bit w, input logic [24:0] a, input bit oe, input bit we,
                         input logic [7:0] d, input logic [26:0] b,
                         output int e_waits, output logic [7:0] e_data, output int e_rises, output int e_wrens);
    logic [26:0] sa;
    if (b != cur_base) m_valid = 0;
    cur_base = b;
    e_rises = 0;
    e_wrens = 0;
    if (oe && !w) begin
      e_waits = 2;
      m_d = sram_ref[a[12:0]];
    end else if (oe) begin
      e_waits = 1;
      if (we) begin
        sram_ref[a[12:0]] = d;
        e_wrens = 1;
      end
    end else if (w) e_waits = 1;
    else if (m_valid && m_tag == a) begin
      e_waits = 1;
      m_d = m_data;
    end else begin
      e_rises = 1;
      m_tag = a;
      if (ack_delay == 0) begin
        e_waits = TIMEOUT + 1;
        m_d = 8'hFF;
        m_valid = 0;
      end else begin
        sa = b + 27'(a);
        e_waits = ack_delay + 2;
        m_d = rom_byte(sa);
        m_data = m_d;
        m_valid = 1;
      end
    end
    e_data = m_d;
  endtask

  task automatic access(input bit w, input logic [24:0] a, input bit oe, input bit we,
                        input logic [7:0] d, input logic [26:0] b,
                        output int waits, output logic [7:0] data, output int rises, output int wrens);
    int r0, w0;
    @(negedge clk);
    r0 = req_rises;
    w0 = wren_cnt;
    cs = 1; rd = !w; wr = w; mem_addr = a; sram_oe = oe; sram_we = we; d_from_cpu = d; rom_base = b;
    #1;
    waits = 0;
    while (!wait_n && waits < TIMEOUT + 50) begin
      waits++;
      @(negedge clk);
      #1;
    end
    data = d_to_cpu;
    cs = 0; rd = 0; wr = 0;
    @(negedge clk);
    @(negedge clk);
    rises = req_rises - r0;
    wrens = wren_cnt - w0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    checks++; if (d_to_cpu !== 8'hFF) begin errors++; $display("FAIL reset_d got %h exp ff", d_to_cpu); end
    checks++; if (wait_n !== 1'b1 || sdram_req !== 1'b0 || bram_wren !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got wait_n=%b req=%b wren=%b exp 1 0 0", wait_n, sdram_req, bram_wren); end
    checks++; if (sdram_addr !== 27'd0 || bram_addr !== 13'd0 || bram_din !== 8'd0) begin
      errors++; $display("FAIL reset_addr got %h %h %h exp 0 0 0", sdram_addr, bram_addr, bram_din); end
    reset = 0;
  endtask

  task automatic test_rom_miss_hit;
    int ew, er, ewr, wt, r, wn;
    logic [7:0] ed, dt;
    ack_delay = 4;
    predict(0, 25'h4000, 0, 0, 0, 27'h100000, ew, ed, er, ewr);
    access(0, 25'h4000, 0, 0, 0, 27'h100000, wt, dt, r, wn);
    checks++; if (wt !== 6 || wt !== ew) begin errors++; $display("FAIL miss_waits got %0d exp 6", wt); end
    checks++; if (dt !== 8'hA5 || dt !== ed) begin errors++; $display("FAIL miss_data got %h exp a5", dt); end
    checks++; if (r !== 1) begin errors++; $display("FAIL miss_req got %0d exp 1", r); end
    checks++; if (ack_addr !== 27'h104000) begin errors++; $display("FAIL miss_addr got %h exp 104000", ack_addr); end
    predict(0, 25'h4000, 0, 0, 0, 27'h100000, ew, ed, er, ewr);
    access(0, 25'h4000, 0, 0, 0, 27'h100000, wt, dt, r, wn);
    checks++; if (wt !== 1 || wt !== ew) begin errors++; $display("FAIL hit_waits got %0d exp 1", wt); end
    checks++; if (dt !== 8'hA5) begin errors++; $display("FAIL hit_data got %h exp a5", dt); end
    checks++; if (r !== 0) begin errors++; $display("FAIL hit_req got %0d exp 0", r); end
  endtask

  task automatic test_sram;
    int ew, er, ewr, wt, r, wn;
    logic [7:0] ed, dt;
    predict(1, 25'h0123, 1, 1, 8'h3C, cur_base, ew, ed, er, ewr);
    access(1, 25'h0123, 1, 1, 8'h3C, cur_base, wt, dt, r, wn);
    checks++; if (wn !== 1 || wn !== ewr) begin errors++; $display("FAIL sram_wren_count got %0d exp 1", wn); end
    checks++; if (wren_addr !== 13'h123 || wren_data !== 8'h3C) begin
      errors++; $display("FAIL sram_wren_data got %h:%h exp 123:3c", wren_addr, wren_data); end
    checks++; if (wt !== 1) begin errors++; $display("FAIL sram_wr_waits got %0d exp 1", wt); end
    predict(0, 25'h0123, 1, 1, 0, cur_base, ew, ed, er, ewr);
    access(0, 25'h0123, 1, 1, 0, cur_base, wt, dt, r, wn);
    checks++; if (wt !== 2 || wt !== ew) begin errors++; $display("FAIL sram_rd_waits got %0d exp 2", wt); end
    checks++; if (dt !== 8'h3C || dt !== ed) begin errors++; $display("FAIL sram_rd_data got %h exp 3c", dt); end
  endtask

  task automatic test_protected;
    int ew, er, ewr, wt, r, wn;
    logic [7:0] ed, dt;
    predict(1, 25'h0123, 1, 0, 8'h55, cur_base, ew, ed, er, ewr);
    access(1, 25'h0123, 1, 0, 8'h55, cur_base, wt, dt, r, wn);
    checks++; if (wn !== 0) begin errors++; $display("FAIL prot_wren got %0d exp 0", wn); end
    checks++; if (wt !== 1) begin errors++; $display("FAIL prot_waits got %0d exp 1", wt); end
    predict(0, 25'h0123, 1, 0, 0, cur_base, ew, ed, er, ewr);
    access(0, 25'h0123, 1, 0, 0, cur_base, wt, dt, r, wn);
    checks++; if (dt !== 8'h3C || dt !== ed) begin errors++; $display("FAIL prot_readback got %h exp 3c", dt); end
  endtask

  task automatic test_timeout;
    int ew, er, ewr, wt, r, wn;
    logic [7:0] ed, dt;
    ack_delay = 0;
    predict(0, 25'h8000, 0, 0, 0, 27'h100000, ew, ed, er, ewr);
    access(0, 25'h8000, 0, 0, 0, 27'h100000, wt, dt, r, wn);
    checks++; if (wt !== TIMEOUT + 1 || wt !== ew) begin errors++; $display("FAIL tmo_waits got %0d exp %0d", wt, TIMEOUT + 1); end
    checks++; if (dt !== 8'hFF) begin errors++; $display("FAIL tmo_data got %h exp ff", dt); end
    ack_delay = 2;
    predict(0, 25'h8000, 0, 0, 0, 27'h100000, ew, ed, er, ewr);
    access(0, 25'h8000, 0, 0, 0, 27'h100000, wt, dt, r, wn);
    checks++; if (r !== 1 || r !== er) begin errors++; $display("FAIL tmo_retry_req got %0d exp 1", r); end
    checks++; if (dt !== ed || wt !== ew) begin errors++; $display("FAIL tmo_retry got %h/%0d exp %h/%0d", dt, wt, ed, ew); end
  endtask

  task automatic test_invalidate;
    int ew, er, ewr, wt, r, wn;
    logic [7:0] ed, dt;
    ack_delay = 3;
    predict(0, 25'h4000, 0, 0, 0, 27'h100000, ew, ed, er, ewr);
    access(0, 25'h4000, 0, 0, 0, 27'h100000, wt, dt, r, wn);
    predict(0, 25'h4000, 0, 0, 0, 27'h100000, ew, ed, er, ewr);
    access(0, 25'h4000, 0, 0, 0, 27'h100000, wt, dt, r, wn);
    checks++; if (r !== 0 || wt !== 1) begin errors++; $display("FAIL inv_prehit got req=%0d waits=%0d exp 0 1", r, wt); end
    predict(0, 25'h4000, 0, 0, 0, 27'h200000, ew, ed, er, ewr);
    access(0, 25'h4000, 0, 0, 0, 27'h200000, wt, dt, r, wn);
    checks++; if (r !== 1) begin errors++; $display("FAIL inv_req got %0d exp 1", r); end
    checks++; if (ack_addr !== 27'h204000) begin errors++; $display("FAIL inv_addr got %h exp 204000", ack_addr); end
    checks++; if (dt !== ed) begin errors++; $display("FAIL inv_data got %h exp %h", dt, ed); end
  endtask

  task automatic test_held_strobe;
    int ew, er, ewr, r0;
    logic [7:0] ed;
    ack_delay = 5;
    predict(0, 25'h4100, 0, 0, 0, cur_base, ew, ed, er, ewr);
    @(negedge clk);
    r0 = req_rises;
    cs = 1; rd = 1; wr = 0; mem_addr = 25'h4100; sram_oe = 0; sram_we = 0;
    repeat (20) @(negedge clk);
    checks++; if (req_rises - r0 !== 1) begin errors++; $display("FAIL held_req got %0d exp 1", req_rises - r0); end
    checks++; if (wait_n !== 1'b1 || d_to_cpu !== ed) begin
      errors++; $display("FAIL held_hold got wait_n=%b d=%h exp 1 %h", wait_n, d_to_cpu, ed); end
    cs = 0; rd = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int ew, er, ewr, wt, r, wn;
    logic [7:0] ed, dt;
    ack_delay = 0;
    @(negedge clk);
    cs = 1; rd = 1; mem_addr = 25'h1234; sram_oe = 0;
    repeat (3) @(negedge clk);
    checks++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before got %b exp 1", sdram_req); end
    reset = 1; cs = 0; rd = 0;
    @(negedge clk);
    checks++; if (sdram_req !== 1'b0 || wait_n !== 1'b1 || d_to_cpu !== 8'hFF) begin
      errors++; $display("FAIL rstmid got req=%b wait_n=%b d=%h exp 0 1 ff", sdram_req, wait_n, d_to_cpu); end
    reset = 0;
    m_valid = 0;
    m_d = 8'hFF;
    ack_delay = 1;
    predict(0, 25'h1234, 0, 0, 0, cur_base, ew, ed, er, ewr);
    access(0, 25'h1234, 0, 0, 0, cur_base, wt, dt, r, wn);
    checks++; if (dt !== ed || wt !== ew || r !== 1) begin
      errors++; $display("FAIL rstmid_after got %h/%0d/%0d exp %h/%0d/1", dt, wt, r, ed, ew); end
  endtask

  task automatic test_random;
    int ew, er, ewr, wt, r, wn;
    logic [7:0] ed, dt, d;
    bit w, oe, we;
    logic [24:0] a;
    logic [26:0] b;
    b = cur_base;
    for (int i = 0; i < 60; i++) begin
      w = $urandom_range(0, 3) == 0;
      oe = $urandom_range(0, 1) == 1;
      we = $urandom_range(0, 3) != 0;
      d = 8'($urandom);
      a = oe ? {12'($urandom), 13'($urandom_range(0, 7))} : 25'h4000 + 25'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) b = (b == 27'h100000) ? 27'h7FFC000 : 27'h100000;
      ack_delay = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
      predict(w, a, oe, we, d, b, ew, ed, er, ewr);
      access(w, a, oe, we, d, b, wt, dt, r, wn);
      checks++; if (wt !== ew || dt !== ed || r !== er || wn !== ewr) begin
        errors++;
        $display("FAIL rand%0d got waits=%0d d=%h req=%0d wren=%0d exp %0d %h %0d %0d", i, wt, dt, r, wn, ew, ed, er, ewr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      bram[i] = 8'h00;
      sram_ref[i] = 8'h00;
    end
    test_reset();
    test_rom_miss_hit();
    test_sram();
    test_protected();
    test_timeout();
    test_invalidate();
    test_held_strobe();
    test_reset_mid();
    test_random();
    checks++; if (addr_moves !== 0) begin errors++; $display("FAIL sdram_addr_stable got %0d changes exp 0", addr_moves); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cart_mem_port.md
# cart_mem_port

Memory-access stage directly downstream of the cartridge mappers. Takes the mapped `mem_addr` / `sram_oe` / `sram_we` from the selected mapper together with the CPU strobes, and turns each CPU access into a one-shot request. A ROM read goes to the shared SDRAM request/ack port, with a one-entry read cache in front of it. A battery-SRAM access goes to an on-chip BRAM. The stage holds the Z80 via `wait_n` until the read data is valid.

## Interface
Parameters:
- `SRAM_AW`, default 13: BRAM address width (8 KiB cartridge SRAM).
- `TIMEOUT`, default 255: SDRAM ack timeout in clk cycles, 8-bit.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cs` in 1: slot/cartridge select for the current CPU cycle.
- `rd` in 1: CPU read strobe, active-high.
- `wr` in 1: CPU write strobe, active-high.
- `d_from_cpu` in 8: write data.
- `mem_addr` in 25: mapped address from the mapper.
- `sram_oe` in 1: from the mapper; access targets SRAM.
- `sram_we` in 1: from the mapper; write to SRAM permitted.
- `rom_base` in 27: SDRAM byte offset of this cartridge image.
- `d_to_cpu` out 8: read data, valid while in HOLD.
- `wait_n` out 1: low = CPU must wait.
- `sdram_addr` out 27: SDRAM byte address.
- `sdram_req` out 1: level request, held until ack.
- `sdram_ack` in 1: single-cycle acknowledge; data valid in the same cycle.
- `sdram_dout` in 8: SDRAM read data.
- `bram_addr` out SRAM_AW: BRAM address.
- `bram_din` out 8: BRAM write data.
- `bram_wren` out 1: BRAM write enable.
- `bram_dout` in 8: BRAM read data, 1-cycle registered latency.

## Operation
- Access start: `start = cs & (rd|wr) & ~act_q`. `act_q` is the registered value of `cs & (rd|wr)`. A held strobe produces exactly one start.
- FSM states: IDLE, SRAM_RD, ROM_REQ, HOLD.
- IDLE handles `start` by access type:
  - `sram_oe & rd`: drive `bram_addr = mem_addr[SRAM_AW-1:0]`, go to SRAM_RD.
  - `sram_oe & wr`: pulse `bram_wren = sram_we` for one cycle with `bram_din = d_from_cpu`, go to HOLD. `sram_oe & ~sram_we` writes are dropped.
  - `~sram_oe & rd`, cache hit (`cvalid` and `ctag == mem_addr`): latch the cache data, go to HOLD.
  - `~sram_oe & rd`, miss: `sdram_addr = rom_base + mem_addr` (27-bit add, carry discarded), go to ROM_REQ.
  - `~sram_oe & wr`: ROM write, ignored; go to HOLD. The mapper has already latched its bank register.
- SRAM_RD: latch `bram_dout` into `d_to_cpu`, go to HOLD.
- ROM_REQ:
  - `sdram_req` is high for the whole state.
  - On `sdram_ack`: latch `sdram_dout`, set `ctag = mem_addr` and `cvalid = 1`, go to HOLD.
  - Timeout counter increments each cycle in ROM_REQ. When it reaches TIMEOUT: `d_to_cpu = 8'hFF`, `cvalid = 0`, drop req, go to HOLD.
- HOLD: return to IDLE when `cs & (rd|wr)` goes low.
- Cache invalidation (`cvalid = 0`) on reset, and in any cycle where `rom_base` differs from its registered copy.
- If `cs` drops while in ROM_REQ, the SDRAM transaction still completes (ack is consumed) before going to HOLD. This prevents orphaned acks.

## Timing
- `wait_n = ~(start | state==SRAM_RD | state==ROM_REQ)`. It is combinational, so wait is asserted in the same cycle as the start.
- Latency from start to HOLD (data valid):
  - cache hit: 1 cycle
  - SRAM read: 2 cycles
  - SRAM write or ROM write: 1 cycle
  - ROM miss: ack cycle + 1
- `sdram_req` rises on the clock after start and falls on the clock after ack.
- `sdram_addr` is stable for the whole ROM_REQ state.
- Reset values: state IDLE, `d_to_cpu = 8'hFF`, `wait_n = 1`, `sdram_req = 0`, `sdram_addr = 0`, `bram_wren = 0`, `bram_addr = 0`, `bram_din = 0`, `cvalid = 0`, timeout counter 0.
- Reset mid-ROM_REQ: the request is dropped immediately. The owning arbiter is also reset, so a late ack is ignored.
- `d_to_cpu` keeps its last value outside HOLD.

## Test plan
- ROM miss then hit:
  - Read `mem_addr = 25'h4000`, `rom_base = 27'h100000`, ack after 5 cycles with `8'hA5` → `sdram_addr = 27'h104000`, `wait_n` low 6 cycles, `d_to_cpu = A5`.
  - Repeat the same read → no `sdram_req`, wait low 1 cycle, data `A5`.
- SRAM write/read: write `8'h3C` to `mem_addr = 13'h0123` with `sram_oe = sram_we = 1` → single `bram_wren` pulse at address `0x123`. Read back → data `3C` after 2 wait cycles.
- Protected SRAM write: `sram_oe = 1`, `sram_we = 0`, write → `bram_wren` stays 0 and `wait_n` is released after 1 cycle.
- Timeout: ROM miss with ack never asserted → wait released after TIMEOUT+1 cycles, `d_to_cpu = FF`. The next identical read issues a new `sdram_req`.
- Invalidate: after a hit is established, change `rom_base` to `27'h200000` and read the same address → new SDRAM request to `27'h204000`.
- Held strobe and reset: keep `rd` high for 20 cycles → exactly one `sdram_req`. Assert reset during ROM_REQ → next cycle `sdram_req = 0`, `wait_n = 1`, `d_to_cpu = FF`.
